// File: rtl/sll_pkg.sv
// Shared constants and helpers for the 8-bit pipelined logical-left shifter.
// Used by the combinational shift core and the two-stage pipeline wrapper.
package sll_pkg;

    localparam int DATA_W  = 8;
    localparam int SHAMT_W = 3;
    localparam int LATENCY = 2;

    function automatic logic is_zero(input logic [DATA_W-1:0] value);
        return (value == {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/sll_core_8.sv
// Combinational logical-left shifter: cascaded shift-by-1/2/4 stages with
// shifted-out bit tracking, plus an override that flushes everything when b >= 8.
module sll_core_8
    import sll_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] s,
    output logic              ovf
);

    logic [DATA_W-1:0] st1_s;
    logic [DATA_W-1:0] st2_s;
    logic [DATA_W-1:0] st4_s;
    logic              ovf1_s;
    logic              ovf2_s;
    logic              ovf4_s;
    logic              big_s;

    // Each stage shifts by its weight and accumulates any set bit it pushes past the MSB.
    always_comb begin
        st1_s  = a;
        ovf1_s = 1'b0;
        if (b[0]) begin
            st1_s  = {a[DATA_W-2:0], 1'b0};
            ovf1_s = a[DATA_W-1];
        end else begin
            st1_s  = a;
            ovf1_s = 1'b0;
        end

        st2_s  = st1_s;
        ovf2_s = ovf1_s;
        if (b[1]) begin
            st2_s  = {st1_s[DATA_W-3:0], 2'b00};
            ovf2_s = ovf1_s | (|st1_s[DATA_W-1:DATA_W-2]);
        end else begin
            st2_s  = st1_s;
            ovf2_s = ovf1_s;
        end

        st4_s  = st2_s;
        ovf4_s = ovf2_s;
        if (b[2]) begin
            st4_s  = {st2_s[DATA_W-5:0], 4'b0000};
            ovf4_s = ovf2_s | (|st2_s[DATA_W-1:DATA_W-4]);
        end else begin
            st4_s  = st2_s;
            ovf4_s = ovf2_s;
        end
    end

    // Any amount of 8 or more pushes every bit of a out of the word.
    always_comb begin
        big_s = |b[DATA_W-1:SHAMT_W];
        s     = st4_s;
        ovf   = ovf4_s;
        if (big_s) begin
            s   = {DATA_W{1'b0}};
            ovf = |a;
        end else begin
            s   = st4_s;
            ovf = ovf4_s;
        end
    end

endmodule

// File: rtl/sll_pipe_8.sv
// Two-stage valid/ready pipeline around sll_core_8: S1 holds operands, S2 holds
// the registered result. Both stages advance together when the output drains.
module sll_pipe_8
    import sll_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] s,
    output logic              ovf,
    output logic              zero
);

    logic              s1_valid_r;
    logic [DATA_W-1:0] s1_a_r;
    logic [DATA_W-1:0] s1_b_r;
    logic              s2_valid_r;
    logic [DATA_W-1:0] s2_s_r;
    logic              s2_ovf_r;
    logic              s2_zero_r;
    logic              s2_load_s;
    logic              s1_load_s;
    logic [DATA_W-1:0] core_s_s;
    logic              core_ovf_s;

    sll_core_8 u_core (
        .a   (s1_a_r),
        .b   (s1_b_r),
        .s   (core_s_s),
        .ovf (core_ovf_s)
    );

    // S2 takes S1 whenever it is empty or being drained; S1 refills when it is empty or moving on.
    always_comb begin
        s2_load_s = (~s2_valid_r) | out_ready;
        s1_load_s = (~s1_valid_r) | s2_load_s;
    end

    assign in_ready  = (~rst) & s1_load_s;
    assign out_valid = (~rst) & s2_valid_r;
    assign s         = s2_s_r;
    assign ovf       = s2_ovf_r;
    assign zero      = s2_zero_r;

    // Operand stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {DATA_W{1'b0}};
            s1_b_r     <= {DATA_W{1'b0}};
        end else if (s1_load_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_a_r <= a;
                s1_b_r <= b;
            end
        end
    end

    // Result stage; data only changes when a real operand moves in, so held outputs stay put.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_s_r     <= {DATA_W{1'b0}};
            s2_ovf_r   <= 1'b0;
            s2_zero_r  <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_s_r    <= core_s_s;
                s2_ovf_r  <= core_ovf_s;
                s2_zero_r <= is_zero(core_s_s);
            end
        end
    end

endmodule

// File: tb/tb_sll_pipe_8.sv
// Self-checking bench for sll_pipe_8: directed scenarios plus a randomized
// valid/ready stream scored against an arithmetic reference model.
module tb_sll_pipe_8;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] s;
    logic       ovf;
    logic       zero;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int in_cnt    = 0;
    int out_cnt   = 0;

    logic [9:0] exp_q[$];

    logic       obs_in_ready;
    logic       obs_out_valid;
    logic [7:0] obs_s;
    logic       obs_ovf;
    logic       obs_zero;

    sll_pipe_8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: widen, shift arithmetically, inspect what fell off the top.
    function automatic logic [9:0] ref_sll(input logic [7:0] av, input logic [7:0] bv);
        logic [31:0] wide;
        logic [7:0]  rs;
        logic        rovf;
        if (bv >= 8'd8) begin
            rs   = 8'h00;
            rovf = (av != 8'h00);
        end else begin
            wide = 32'(av) << bv;
            rs   = wide[7:0];
            rovf = (wide[31:8] != 24'd0);
        end
        return {rs, rovf, (rs == 8'h00)};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive after the falling edge, sample mid-low-phase, score transfers.
    task automatic step(input logic iv, input logic [7:0] av, input logic [7:0] bv,
                        input logic ordy, output logic fired);
        logic [9:0] exp_v;
        in_valid  = iv;
        a         = av;
        b         = bv;
        out_ready = ordy;
        #2;
        obs_in_ready  = in_ready;
        obs_out_valid = out_valid;
        obs_s         = s;
        obs_ovf       = ovf;
        obs_zero      = zero;
        fired = iv & in_ready;
        if (out_valid && ordy) begin
            out_cnt++;
            check_val("out_has_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                check_val("result", 32'({s, ovf, zero}), 32'(exp_v));
            end
        end
        if (fired) begin
            exp_q.push_back(ref_sll(av, bv));
            in_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        logic f;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() != 0) step(1'b0, 8'h00, 8'h00, 1'b1, f);
        end
        check_val("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic       f;
        logic [7:0] held_s;
        logic [7:0] op_a[4];
        logic [7:0] op_b[4];
        int         idx;
        logic [9:0] e;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);

        // Reset behaviour.
        step(1'b1, 8'h12, 8'h01, 1'b1, f);
        check_val("rst_in_ready", 32'(obs_in_ready), 32'd0);
        check_val("rst_out_valid", 32'(obs_out_valid), 32'd0);
        step(1'b0, 8'h00, 8'h00, 1'b1, f);
        rst = 1'b0;
        step(1'b0, 8'h00, 8'h00, 1'b1, f);
        check_val("post_rst_outs", 32'({obs_out_valid, obs_s, obs_ovf, obs_zero}), 32'd0);

        // B5 << 3 with 2-cycle latency.
        step(1'b1, 8'hB5, 8'd3, 1'b1, f);
        check_val("b5_accept", 32'(f), 32'd1);
        step(1'b0, 8'h00, 8'h00, 1'b1, f);
        check_val("b5_lat1_invalid", 32'(obs_out_valid), 32'd0);
        step(1'b0, 8'h00, 8'h00, 1'b1, f);
        check_val("b5_lat2_valid", 32'(obs_out_valid), 32'd1);
        check_val("b5_value", 32'({obs_s, obs_ovf, obs_zero}), 32'({8'hA8, 1'b1, 1'b0}));

        // Back-to-back 0F by 0, 4, 9: one result per cycle.
        step(1'b1, 8'h0F, 8'd0, 1'b1, f);
        step(1'b1, 8'h0F, 8'd4, 1'b1, f);
        step(1'b1, 8'h0F, 8'd9, 1'b1, f);
        check_val("b2b_r0", 32'({obs_out_valid, obs_s, obs_ovf, obs_zero}), 32'({1'b1, 8'h0F, 1'b0, 1'b0}));
        step(1'b0, 8'h00, 8'h00, 1'b1, f);
        check_val("b2b_r1", 32'({obs_out_valid, obs_s, obs_ovf, obs_zero}), 32'({1'b1, 8'hF0, 1'b0, 1'b0}));
        step(1'b0, 8'h00, 8'h00, 1'b1, f);
        check_val("b2b_r2", 32'({obs_out_valid, obs_s, obs_ovf, obs_zero}), 32'({1'b1, 8'h00, 1'b1, 1'b1}));
        drain();

        // Zero operand with the maximum shift amount.
        step(1'b1, 8'h00, 8'hFF, 1'b1, f);
        step(1'b0, 8'h00, 8'h00, 1'b1, f);
        step(1'b0, 8'h00, 8'h00, 1'b1, f);
        check_val("zero_ff", 32'({obs_out_valid, obs_s, obs_ovf, obs_zero}), 32'({1'b1, 8'h00, 1'b0, 1'b1}));
        drain();

        // Backpressure: two accepts fill the pipe, then in_ready drops and outputs hold.
        op_a = '{8'hC3, 8'h81, 8'h7E, 8'h01};
        op_b = '{8'd2, 8'd7, 8'd1, 8'd200};
        step(1'b1, op_a[0], op_b[0], 1'b0, f);
        check_val("bp_acc0", 32'(f), 32'd1);
        step(1'b1, op_a[1], op_b[1], 1'b0, f);
        check_val("bp_acc1", 32'(f), 32'd1);
        step(1'b1, op_a[2], op_b[2], 1'b0, f);
        check_val("bp_full_in_ready", 32'(obs_in_ready), 32'd0);
        e = ref_sll(op_a[0], op_b[0]);
        check_val("bp_head", 32'({obs_out_valid, obs_s, obs_ovf, obs_zero}), 32'({1'b1, e}));
        held_s = obs_s;
        step(1'b1, op_a[2], op_b[2], 1'b0, f);
        check_val("bp_still_full", 32'(obs_in_ready), 32'd0);
        check_val("bp_hold", 32'(obs_s), 32'(held_s));
        idx = 2;
        for (int i = 0; i < 20; i++) begin
            if (idx < 4) begin
                step(1'b1, op_a[idx], op_b[idx], 1'b1, f);
                if (f) idx++;
            end
        end
        check_val("bp_all_sent", 32'(idx), 32'd4);
        drain();

        // Reset with both stages full discards everything in flight.
        step(1'b1, 8'h11, 8'd1, 1'b0, f);
        step(1'b1, 8'h22, 8'd2, 1'b0, f);
        rst = 1'b1;
        step(1'b1, 8'h33, 8'd1, 1'b0, f);
        check_val("midrst_in_ready", 32'(obs_in_ready), 32'd0);
        check_val("midrst_out_valid", 32'(obs_out_valid), 32'd0);
        in_cnt = in_cnt - exp_q.size();
        exp_q.delete();
        rst = 1'b0;
        step(1'b0, 8'h00, 8'h00, 1'b1, f);
        check_val("midrst_no_stale", 32'(obs_out_valid), 32'd0);
        step(1'b1, 8'h81, 8'd1, 1'b1, f);
        step(1'b0, 8'h00, 8'h00, 1'b1, f);
        check_val("midrst_lat1", 32'(obs_out_valid), 32'd0);
        step(1'b0, 8'h00, 8'h00, 1'b1, f);
        check_val("midrst_lat2", 32'({obs_out_valid, obs_s, obs_ovf, obs_zero}), 32'({1'b1, 8'h02, 1'b1, 1'b0}));
        drain();

        // Randomized stream with random handshakes.
        for (int i = 0; i < 10000; i++) begin
            logic [7:0] rb;
            rb = ($urandom % 2 == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            step(($urandom % 4) != 0, 8'($urandom), rb, ($urandom % 3) != 0, f);
        end
        drain();
        check_val("in_eq_out", 32'(out_cnt), 32'(in_cnt));

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
